// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: the {pc, instr} entry carried through the fetch queue.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          FETCH_WIDTH = 2;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
// The master modport is the fetch/decode pair; the slave modport is the queue.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic                            flush;
    logic                            fq_in_valid;
    logic                            fq_in_ready;
    logic [31:0]                     fq_in_pc;
    logic [FETCH_WIDTH-1:0][31:0]    fq_in_instr;
    logic [FETCH_WIDTH-1:0]          fq_out_valid;
    logic [FETCH_WIDTH-1:0][31:0]    fq_out_pc;
    logic [FETCH_WIDTH-1:0][31:0]    fq_out_instr;
    logic [1:0]                      fq_deq_count;

    modport master (
        output flush, fq_in_valid, fq_in_pc, fq_in_instr, fq_deq_count,
        input  fq_in_ready, fq_out_valid, fq_out_pc, fq_out_instr
    );

    modport slave (
        input  flush, fq_in_valid, fq_in_pc, fq_in_instr, fq_deq_count,
        output fq_in_ready, fq_out_valid, fq_out_pc, fq_out_instr
    );

endinterface

// File: rtl/fetch_queue.sv
// Dual-width instruction fetch queue: accepts a {pc, instr} pair per fetch cycle,
// presents the oldest two entries to the dual-issue decoder, emptied by flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [CNT_W-1:0]   deq_req;
    logic [CNT_W-1:0]   deq_eff;
    logic               enq;
    logic [PTR_W-1:0]   wr_ptr_p1;
    logic [PTR_W-1:0]   rd_ptr_p1;

    // Ready depends only on the registered count so a same-cycle dequeue never frees space early.
    always_comb begin
        fq.fq_in_ready = (count_q <= CNT_W'(DEPTH - 2));
        enq            = fq.fq_in_valid & fq.fq_in_ready;
        wr_ptr_p1      = wr_ptr_q + PTR_W'(1);
        rd_ptr_p1      = rd_ptr_q + PTR_W'(1);
        deq_req        = CNT_W'(fq.fq_deq_count);
        deq_eff        = (deq_req > count_q) ? count_q : deq_req;
    end

    // Next pointers and occupancy; flush overrides any same-cycle enqueue or dequeue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(deq_eff);
        count_d  = count_q - deq_eff;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(2);
            count_d  = count_q + CNT_W'(2) - deq_eff;
        end
        if (fq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and count registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage writes both slots of an accepted pair; contents are not reset since count gates them.
    always_ff @(posedge clk) begin
        if (enq && !fq.flush) begin
            mem_q[wr_ptr_q]  <= '{pc: fq.fq_in_pc,             instr: fq.fq_in_instr[0]};
            mem_q[wr_ptr_p1] <= '{pc: fq.fq_in_pc + 32'd4,     instr: fq.fq_in_instr[1]};
        end
    end

    // Oldest two entries fall through combinationally; lanes without a valid entry read as zero.
    always_comb begin
        fq.fq_out_valid[0] = (count_q != '0);
        fq.fq_out_valid[1] = (count_q >= CNT_W'(2));
        fq.fq_out_pc       = '0;
        fq.fq_out_instr    = '0;
        if (fq.fq_out_valid[0]) begin
            fq.fq_out_pc[0]    = mem_q[rd_ptr_q].pc;
            fq.fq_out_instr[0] = mem_q[rd_ptr_q].instr;
        end
        if (fq.fq_out_valid[1]) begin
            fq.fq_out_pc[1]    = mem_q[rd_ptr_p1].pc;
            fq.fq_out_instr[1] = mem_q[rd_ptr_p1].instr;
        end
    end

endmodule
